// File: rtl/bcd_event_counter_pkg.sv
// Shared types and helpers for the packed-BCD event counter.
package count_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} cnt_state_t;

  // Clamp an out-of-range nibble to 9 so the counter only ever holds BCD.
  function automatic bcd_digit_t bcd_sanitise(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_event_counter_digit.sv
// One BCD decade: clear > load > step, with terminal-count output for the
// ripple enable chain (9 when counting up, 0 when counting down).
module bcd_digit
  import count_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up_dn,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       clr,
  output logic [3:0] q,
  output logic       tc_out
);

  logic [3:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (ld) begin
      q_d = ld_val;
    end else if (en) begin
      if (up_dn) begin
        q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign tc_out = up_dn ? (q_q == BCD_MAX) : (q_q == 4'd0);

endmodule

// File: rtl/bcd_event_counter.sv
// Packed-BCD up/down event counter with run/hold FSM, wrap or saturate mode,
// sticky overflow. Define EVENT_EDGE_DETECT_EN to synchronise event_in and count its rising edges.
module bcd_event_counter
  import count_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  up_dn,
  input  logic                  event_in,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  ovf,
  output logic                  running
);

  cnt_state_t state_d, state_q;
  logic       carry_d, carry_q;
  logic       ovf_d, ovf_q;
  logic       ev;
  logic       step;
  logic       all_tc;
  logic [DIGITS-1:0] tc;
  logic [DIGITS:0]   en_chain;

`ifdef EVENT_EDGE_DETECT_EN
  // Two synchroniser stages, one history stage, then a registered edge pulse.
  logic [2:0] sync_d, sync_q;
  logic       ev_d, ev_q;

  always_comb begin
    sync_d = {sync_q[1:0], event_in};
    ev_d   = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      ev_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      ev_q   <= ev_d;
    end
  end

  assign ev = ev_q;
`else
  assign ev = event_in;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (stop)  state_d = ST_HOLD;
      ST_HOLD: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // A stop in the same cycle as an event leaves the count untouched.
  assign step   = (state_q == ST_RUN) && !stop && ev && !clear && !load;
  assign all_tc = &tc;

  always_comb begin
    carry_d = step && all_tc;
    ovf_d   = clear ? 1'b0 : (ovf_q | carry_d);
  end

  // Saturating mode stops the ripple when every digit is at its terminal value.
  assign en_chain[0] = step && (WRAP || !all_tc);

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] ld_san;

      assign ld_san          = bcd_sanitise(load_val[4*gi +: 4]);
      assign en_chain[gi+1]  = en_chain[gi] & tc[gi];

      bcd_digit u_digit (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en_chain[gi]),
        .up_dn  (up_dn),
        .ld     (load),
        .ld_val (ld_san),
        .clr    (clear),
        .q      (count[4*gi +: 4]),
        .tc_out (tc[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carry   = carry_q;
  assign ovf     = ovf_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_bcd_event_counter.sv
// Bench for bcd_event_counter: a wrapping and a saturating instance share stimulus;
// constant vector table, hand corner cases, then random traffic against a model.
module tb_bcd_event_counter;

`ifdef EVENT_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, stop, clear, load, up_dn, event_in;
  logic [11:0] load_val;
  logic [11:0] count_a, count_b;
  logic        carry_a, carry_b, ovf_a, ovf_b, running_a, running_b;

  always #5 clk = ~clk;

  bcd_event_counter #(.DIGITS(3), .WRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .up_dn(up_dn), .event_in(event_in),
    .count(count_a), .carry(carry_a), .ovf(ovf_a), .running(running_a)
  );

  bcd_event_counter #(.DIGITS(3), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_val(load_val), .up_dn(up_dn), .event_in(event_in),
    .count(count_b), .carry(carry_b), .ovf(ovf_b), .running(running_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: decimal integer count, index 0 = wrap, 1 = saturate.
  int m_cnt   [2];
  bit m_carry [2];
  bit m_ovf   [2];
  bit m_run;
  bit m_hold;
  bit hist    [1:4];

  function automatic int san(input logic [11:0] v);
    int d [3];
    for (int i = 0; i < 3; i++) begin
      d[i] = int'(v[4*i +: 4]);
      if (d[i] > 9) d[i] = 9;
    end
    return d[2] * 100 + d[1] * 10 + d[0];
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_update();
    bit ev;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0; m_carry[k] = 0; m_ovf[k] = 0;
      end
      m_run = 0; m_hold = 0;
      for (int i = 1; i <= 4; i++) hist[i] = 0;
    end else begin
      ev = EDGE ? (hist[3] && !hist[4]) : event_in;
      for (int k = 0; k < 2; k++) begin
        m_carry[k] = 0;
        if (clear) begin
          m_cnt[k] = 0; m_ovf[k] = 0;
        end else if (load) begin
          m_cnt[k] = san(load_val);
        end else if (m_run && !stop && ev) begin
          if (up_dn) begin
            if (m_cnt[k] == 999) begin
              m_carry[k] = 1; m_ovf[k] = 1;
              m_cnt[k] = (k == 0) ? 0 : 999;
            end else m_cnt[k]++;
          end else begin
            if (m_cnt[k] == 0) begin
              m_carry[k] = 1; m_ovf[k] = 1;
              m_cnt[k] = (k == 0) ? 999 : 0;
            end else m_cnt[k]--;
          end
        end
      end
      if (m_run) begin
        if (stop) begin m_run = 0; m_hold = 1; end
      end else if (start) begin
        m_run = 1; m_hold = 0;
      end
      hist[4] = hist[3]; hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = event_in;
    end
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_count_wrap", count_a, to_bcd(m_cnt[0]));
    check("model_carry_wrap", 12'(carry_a), 12'(m_carry[0]));
    check("model_ovf_wrap", 12'(ovf_a), 12'(m_ovf[0]));
    check("model_running_wrap", 12'(running_a), 12'(m_run));
    check("model_count_sat", count_b, to_bcd(m_cnt[1]));
    check("model_carry_sat", 12'(carry_b), 12'(m_carry[1]));
    check("model_ovf_sat", 12'(ovf_b), 12'(m_ovf[1]));
    check("model_running_sat", 12'(running_b), 12'(m_run));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
    $display("cyc t=%0t rst_n=%b st=%b sp=%b clr=%b ld=%b lv=%h ud=%b ev=%b | wrap %h c%b o%b r%b | sat %h c%b o%b",
             $time, rst_n, start, stop, clear, load, load_val, up_dn, event_in,
             count_a, carry_a, ovf_a, running_a, count_b, carry_b, ovf_b);
  endtask

  task automatic drive(input bit r, input bit s, input bit p, input bit c, input bit l,
                       input logic [11:0] lv, input bit u, input bit e);
    rst_n = r; start = s; stop = p; clear = c; load = l; load_val = lv;
    up_dn = u; event_in = e;
  endtask

  typedef struct {
    bit          r, s, p, c, l, u, e;
    logic [11:0] lv;
    logic [11:0] e_count;
    bit          e_carry, e_ovf, e_run;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit s, input bit p, input bit c,
                              input bit l, input logic [11:0] lv, input bit u, input bit e,
                              input logic [11:0] ec, input bit cy, input bit ov, input bit rn);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.c = c; v.l = l; v.lv = lv; v.u = u; v.e = e;
    v.e_count = ec; v.e_carry = cy; v.e_ovf = ov; v.e_run = rn;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    drive(0, 0, 0, 0, 0, 12'h000, 0, 0);

`ifndef EVENT_EDGE_DETECT_EN
    //            r  s  p  c  l  load_val u  e   count   cy ov rn
    tbl[0]  = mk(0, 0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 1, 12'h198, 1, 0, 12'h198, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h198, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 0, 0, 12'h000, 1, 1, 12'h199, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0, 0, 12'h000, 1, 1, 12'h200, 0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 0, 0, 12'h000, 1, 1, 12'h201, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0, 1, 12'h998, 1, 0, 12'h998, 0, 0, 1);
    tbl[7]  = mk(1, 0, 0, 0, 0, 12'h000, 1, 1, 12'h999, 0, 0, 1);
    tbl[8]  = mk(1, 0, 0, 0, 0, 12'h000, 1, 1, 12'h000, 1, 1, 1);
    tbl[9]  = mk(1, 0, 0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 1, 1);
    tbl[10] = mk(1, 0, 0, 0, 1, 12'h001, 0, 0, 12'h001, 0, 1, 1);
    tbl[11] = mk(1, 0, 0, 0, 0, 12'h000, 0, 1, 12'h000, 0, 1, 1);
    tbl[12] = mk(1, 0, 0, 0, 0, 12'h000, 0, 1, 12'h999, 1, 1, 1);
    tbl[13] = mk(1, 0, 0, 1, 0, 12'h000, 0, 0, 12'h000, 0, 0, 1);
    tbl[14] = mk(1, 0, 0, 0, 1, 12'h050, 1, 0, 12'h050, 0, 0, 1);
    tbl[15] = mk(1, 0, 1, 0, 0, 12'h000, 1, 1, 12'h050, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 12'h000, 1, 1, 12'h050, 0, 0, 0);
    tbl[17] = mk(1, 1, 0, 0, 0, 12'h000, 1, 0, 12'h050, 0, 0, 1);
    tbl[18] = mk(1, 0, 0, 0, 0, 12'h000, 1, 1, 12'h051, 0, 0, 1);
    tbl[19] = mk(1, 0, 0, 0, 1, 12'hA3F, 1, 0, 12'h939, 0, 0, 1);
    tbl[20] = mk(1, 0, 0, 1, 1, 12'h555, 1, 1, 12'h000, 0, 0, 1);
    tbl[21] = mk(1, 0, 0, 0, 1, 12'h123, 1, 0, 12'h123, 0, 0, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 12'h000, 1, 1, 12'h000, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 0, 0, 12'h000, 1, 1, 12'h000, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].u, tbl[i].e);
      step();
      check($sformatf("tbl%0d_count", i), count_a, tbl[i].e_count);
      check($sformatf("tbl%0d_carry", i), 12'(carry_a), 12'(tbl[i].e_carry));
      check($sformatf("tbl%0d_ovf", i), 12'(ovf_a), 12'(tbl[i].e_ovf));
      check($sformatf("tbl%0d_running", i), 12'(running_a), 12'(tbl[i].e_run));
    end

    // Saturating instance: 001 counted down twice holds at 000 with flags.
    drive(0, 0, 0, 0, 0, 12'h000, 0, 0); step();
    drive(1, 0, 0, 0, 1, 12'h001, 0, 0); step();
    drive(1, 1, 0, 0, 0, 12'h000, 0, 0); step();
    drive(1, 0, 0, 0, 0, 12'h000, 0, 1); step();
    check("sat_down_first", count_b, 12'h000);
    check("sat_down_first_carry", 12'(carry_b), 12'h000);
    drive(1, 0, 0, 0, 0, 12'h000, 0, 1); step();
    check("sat_down_hold", count_b, 12'h000);
    check("sat_down_carry", 12'(carry_b), 12'h001);
    check("sat_down_ovf", 12'(ovf_b), 12'h001);
    check("wrap_down_999", count_a, 12'h999);
    drive(1, 0, 0, 0, 1, 12'h999, 1, 0); step();
    drive(1, 0, 0, 0, 0, 12'h000, 1, 1); step();
    check("sat_up_hold", count_b, 12'h999);
    check("sat_up_carry", 12'(carry_b), 12'h001);
    drive(1, 0, 0, 0, 0, 12'h000, 1, 0); step();
    check("sat_carry_pulse_end", 12'(carry_b), 12'h000);
    check("sat_ovf_sticky", 12'(ovf_b), 12'h001);
`else
    // Edge mode: a 5-cycle-high event gives exactly one count, 3 cycles late.
    drive(0, 0, 0, 0, 0, 12'h000, 0, 0); step();
    check("edge_reset_count", count_a, 12'h000);
    drive(1, 0, 0, 0, 1, 12'h010, 1, 0); step();
    drive(1, 1, 0, 0, 0, 12'h000, 1, 0); step();
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0, 0, 0, 12'h000, 1, 1); step();
      check($sformatf("edge_hi%0d", i), count_a, (i >= 4) ? 12'h011 : 12'h010);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 0, 0, 12'h000, 1, 0); step();
      check($sformatf("edge_lo%0d", i), count_a, 12'h011);
    end
`endif

    // Random traffic against the model.
    drive(0, 0, 0, 0, 0, 12'h000, 1, 0); step();
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < 12),
            ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 5),
            12'($urandom),
            ($urandom_range(0, 99) < 60),
            ($urandom_range(0, 99) < 50));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
